gray_count_monitor: RTL and testbench

Receiving end of the timer's 4-bit Gray-code counter bus. Samples the Gray count when its enable is high, decodes it to binary, and checks that every change is a single legal forward step in reflected-binary Gray order. It reports wrap-arounds (terminal count 4'b1000 followed by 4'b0000) and sequence errors. It sits next to the Gray counter in the timer datapath and gives downstream compare and interrupt logic a verified binary count.

---
 rtl/gray_count_monitor.sv | 98 +++++++++
 tb/tb_gray_count_monitor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/gray_count_monitor.sv
// Gray-code counter bus monitor: samples the Gray count, decodes it to binary, and
// flags every change that is not a single forward step in reflected-binary order.
module gray_count_monitor #(
    parameter int unsigned W  = 4,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          en,
    input  logic [W-1:0]  gray_in,
    output logic [W-1:0]  bin_out,
    output logic          valid,
    output logic          step,
    output logic          wrap,
    output logic [CW-1:0] wrap_cnt,
    output logic          err,
    output logic          err_flag,
    output logic [CW-1:0] err_cnt
);

    typedef enum logic [0:0] {StUnlocked, StLocked} state_e;

    localparam logic [W-1:0] One = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] Tc  = {1'b1, {(W-1){1'b0}}};

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = int'(W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_e       r_state;
    logic [W-1:0] r_g;

    logic [W-1:0] w_in_bin;
    logic [W-1:0] w_g_bin;
    logic [W-1:0] w_nb;
    logic [W-1:0] w_exp;

    always_comb begin
        w_in_bin = gray2bin(gray_in);
        w_g_bin  = gray2bin(r_g);
        w_nb     = w_g_bin + One;
        w_exp    = w_nb ^ (w_nb >> 1);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state  <= StUnlocked;
            r_g      <= '0;
            bin_out  <= '0;
            valid    <= 1'b0;
            step     <= 1'b0;
            wrap     <= 1'b0;
            wrap_cnt <= '0;
            err      <= 1'b0;
            err_flag <= 1'b0;
            err_cnt  <= '0;
        end else begin
            step <= 1'b0;
            wrap <= 1'b0;
            err  <= 1'b0;
            if (en) begin
                unique case (r_state)
                    StUnlocked: begin
                        r_g     <= gray_in;
                        bin_out <= w_in_bin;
                        valid   <= 1'b1;
                        r_state <= StLocked;
                    end
                    StLocked: begin
                        // An unchanged sample is a stall: hold everything silently.
                        if (gray_in != r_g) begin
                            r_g     <= gray_in;
                            bin_out <= w_in_bin;
                            if (gray_in == w_exp) begin
                                step <= 1'b1;
                                if (r_g == Tc) begin
                                    wrap <= 1'b1;
                                    if (wrap_cnt != '1) wrap_cnt <= wrap_cnt + 1'b1;
                                end
                            end else begin
                                err      <= 1'b1;
                                err_flag <= 1'b1;
                                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                            end
                        end
                    end
                    default: r_state <= StUnlocked;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gray_count_monitor.sv
// Randomized and directed bench for gray_count_monitor against a table-based
// reference model of the Gray sequence.
module tb_gray_count_monitor;

    localparam int W  = 4;
    localparam int CW = 8;
    localparam int N  = 1 << W;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          en = 1'b0;
    logic [W-1:0]  gray_in = '0;
    logic [W-1:0]  bin_out;
    logic          valid, step, wrap, err, err_flag;
    logic [CW-1:0] wrap_cnt, err_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_locked, m_valid, m_step, m_wrap, m_err, m_err_flag;
    int m_bin, m_wcnt, m_ecnt;
    int wrap_pulses, exp_wrap_pulses;

    gray_count_monitor #(.W(W), .CW(CW)) dut (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .gray_in  (gray_in),
        .bin_out  (bin_out),
        .valid    (valid),
        .step     (step),
        .wrap     (wrap),
        .wrap_cnt (wrap_cnt),
        .err      (err),
        .err_flag (err_flag),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int from_gray(input int g);
        for (int k = 0; k < N; k++) begin
            if (to_gray(k) == g) return k;
        end
        return -1;
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("bin_out", int'(bin_out), m_bin);
        check_eq("valid", int'(valid), int'(m_valid));
        check_eq("step", int'(step), int'(m_step));
        check_eq("wrap", int'(wrap), int'(m_wrap));
        check_eq("err", int'(err), int'(m_err));
        check_eq("err_flag", int'(err_flag), int'(m_err_flag));
        check_eq("wrap_cnt", int'(wrap_cnt), m_wcnt);
        check_eq("err_cnt", int'(err_cnt), m_ecnt);
    endtask

    task automatic model_reset();
        m_locked = 0; m_valid = 0; m_step = 0; m_wrap = 0; m_err = 0; m_err_flag = 0;
        m_bin = 0; m_wcnt = 0; m_ecnt = 0;
    endtask

    task automatic model_sample(input bit e, input int g);
        m_step = 0; m_wrap = 0; m_err = 0;
        if (!e) return;
        if (!m_locked) begin
            m_locked = 1; m_valid = 1; m_bin = from_gray(g);
        end else if (g == to_gray(m_bin)) begin
            // stall
        end else if (from_gray(g) == (m_bin + 1) % N) begin
            m_step = 1;
            if (m_bin == N - 1) begin
                m_wrap = 1;
                exp_wrap_pulses++;
                if (m_wcnt < CMAX) m_wcnt++;
            end
            m_bin = from_gray(g);
        end else begin
            m_err = 1; m_err_flag = 1;
            if (m_ecnt < CMAX) m_ecnt++;
            m_bin = from_gray(g);
        end
    endtask

    task automatic drive(input bit e, input int g);
        en = e;
        gray_in = W'(g);
        @(posedge clk);
        model_sample(e, g);
        #1;
        if (wrap) wrap_pulses++;
        check_all();
    endtask

    task automatic do_clear();
        @(posedge clk);
        #1;
        clr = 1;
        model_reset();
        #1;
        check_all();
        #1;
        clr = 0;
    endtask

    initial begin
        int g;
        model_reset();
        clr = 1;
        #3;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        clr = 0;

        // Full sequence with wrap back to 0
        for (int i = 0; i <= N; i++) drive(1, to_gray(i % N));

        // Stall then step
        do_clear();
        drive(1, 'b0110);
        for (int i = 0; i < 5; i++) drive(1, 'b0110);
        drive(1, 'b0111);

        // Two-bit jump, then legal step with sticky flag
        do_clear();
        drive(1, 'b0011);
        drive(1, 'b0110);
        drive(1, 'b0111);

        // Backward step
        do_clear();
        drive(1, 'b0010);
        drive(1, 'b0011);

        // Wrap counter saturation, with random en gaps
        do_clear();
        wrap_pulses = 0;
        exp_wrap_pulses = 0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) drive(0, $urandom_range(0, N - 1));
                drive(1, to_gray(i));
            end
        end
        drive(1, 0);
        check_eq("wrap_pulse_count", wrap_pulses, exp_wrap_pulses);
        check_eq("wrap_cnt_sat", int'(wrap_cnt), CMAX);

        // Mid-sequence clear at 0101, first sample after release is 1100
        do_clear();
        for (int i = 0; i <= 6; i++) drive(1, to_gray(i));
        do_clear();
        drive(1, 'b1100);
        check_eq("post_clr_bin", int'(bin_out), 8);

        // Random mix of legal steps, stalls, garbage and idle cycles
        do_clear();
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5)      g = to_gray((m_bin + 1) % N);
            else if (r <= 7) g = to_gray(m_bin);
            else             g = $urandom_range(0, N - 1);
            drive($urandom_range(0, 3) != 0, g);
            if (i == 1000 && $urandom_range(0, 1) == 1) do_clear();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
